multicycle_control: RTL and testbench
=====================================

# multicycle_control

Multi-cycle control FSM and program counter for the 16-bit CPU. It sits directly upstream of the datapath and owns the PC register. Each cycle it drives the 15-bit control vector `signal` from the current state and the decoded `opcode`/`func`. It also latches the datapath's `nextPC` every active cycle.

## Interface
- No parameters.
- `clk` input 1: clock; all state updates on rising edge.
- `reset_n` input 1: reset, synchronous, active-low.
- `opcode` input 4: instruction[15:12] from the datapath instruction register.
- `func` input 6: instruction[5:0] from the datapath instruction register.
- `nextPC` input 16: next-PC value computed by the datapath.
- `PC` output 16: program counter fed to the datapath.
- `signal` output 15: control vector, with this bit layout:
  - [14:13] PCSource
  - [12] ALUOp
  - [11:10] ALUSrcB
  - [9] ALUSrcA
  - [8] RegWrite
  - [7] RegDst
  - [6] PCWriteCond
  - [5] PCWrite
  - [4] IorD
  - [3] MemRead
  - [2] MemWrite
  - [1] MemtoReg
  - [0] IRWrite
- `state` output 3: current FSM state, for debug.
- `is_halted` output 1: high while the FSM is in HALT.
- `num_inst` output 16: count of retired instructions.

## Operation
- State encoding: IF=0, ID=1, EX=2, MEM=3, WB=4, HALT=5. Codes 6 and 7 go to IF on the next edge.
- `signal` is a Moore output of state, plus the opcode class for states EX, MEM and WB.
- Opcode classes:
  - Branch: opcodes 0–3 (BNE, BEQ, BGZ, BLZ).
  - ADI: 4. ORI: 5. LHI: 6. LWD: 7. SWD: 8. JMP: 9.
  - R-type: 15 with func 0–7.
  - WWD: 15 with func 28.
  - HLT: 15 with func 29.
  - Everything else is illegal.
- Control vector per state and class:
  - IF: 15'h0429 (MemRead, IRWrite, PC+1 via ALUSrcB=01, PCWrite).
  - ID: 15'h0800 (branch-target precompute).
  - EX, R-type and WWD: 15'h1200.
  - EX, ADI, LHI, LWD and SWD: 15'h1A00.
  - EX, ORI: 15'h1E00.
  - EX, branch: 15'h2240 (PCSource=01, PCWriteCond).
  - EX, JMP: 15'h4020.
  - MEM, LWD: 15'h0018.
  - MEM, SWD: 15'h0014.
  - WB, R-type and WWD: 15'h0180.
  - WB, ADI, ORI and LHI: 15'h0100.
  - WB, LWD: 15'h0102.
  - HALT: 15'h0000.
- Transitions:
  - IF→ID unconditionally.
  - ID→HALT on HLT; ID→IF on an illegal instruction; otherwise ID→EX.
  - EX→IF for branch and JMP; EX→MEM for LWD and SWD; EX→WB otherwise.
  - MEM→WB for LWD; MEM→IF for SWD.
  - WB→IF.
  - HALT→HALT until reset.
- PC: `PC <= nextPC` on every edge in states IF–WB. PC holds in HALT.
- `num_inst` (when the counter is enabled):
  - +1 on the edge leaving ID with a legal, non-HLT instruction.
  - 16-bit, wraps from 16'hFFFF to 0.
  - Illegal instructions and HLT are not counted.

## Timing
- Reset values:
  - state=IF, PC=16'h0000, num_inst=0, is_halted=0.
  - `signal`=15'h0429, since it is combinational from IF.
- Reset applied mid-instruction, or while in HALT: on the next edge, return to IF with PC=0 and num_inst=0. Reset has priority over every other update.
- Cycles per instruction, IF edge to next IF edge:
  - branch: 3
  - JMP: 3
  - R-type, WWD, ADI, ORI, LHI: 4
  - SWD: 4
  - LWD: 5
  - illegal: 2
- HLT: reaches HALT after 2 cycles; `is_halted` rises in the same cycle the state becomes HALT.
- `signal` changes only after a clock edge (state change). The `opcode`/`func` inputs are sampled combinationally and must be stable from the end of IF onward.
- The RegWrite pulse for WWD is exactly 1 cycle, in WB.

## Configuration
- Macro: `MULTICYCLE_INST_COUNT_EN`.
  - Defined: the `num_inst` counter is implemented as described above.
  - Undefined: the counter register is removed and `num_inst` is tied to 16'h0000. All other behaviour is identical.

## Test plan
- Reset with reset_n=0 for 2 cycles, then release → state=0, PC=0, `signal`=15'h0429, num_inst=0.
- opcode=15, func=0 (ADD), with nextPC driven as PC+1 in IF and as PC otherwise → `signal` sequence 0429, 0800, 1200, 0180; back in IF at cycle 4; PC=1; num_inst=1.
- opcode=7 (LWD) → `signal` sequence 0429, 0800, 1A00, 0018, 0102; 5 cycles; MEM→WB taken.
- opcode=9 (JMP), with nextPC=16'h0ABC in EX → `signal` in EX is 4020; PC=16'h0ABC on return to IF after 3 cycles.
- opcode=15, func=29 (HLT) → HALT after 2 cycles; is_halted=1; `signal`=0; PC frozen for 10 cycles while nextPC toggles; then reset_n=0 → IF, PC=0.
- Counter: preload by running 65535 ADDs (or force num_inst=16'hFFFF), then run one ADI → num_inst=0. Opcode 11 (illegal) → ID→IF in 2 cycles with num_inst unchanged. With `MULTICYCLE_INST_COUNT_EN` undefined, num_inst stays 0 throughout.

Source files
------------

// File: rtl/multicycle_control.sv
// Multi-cycle control FSM and program counter for the 16-bit CPU.
// Define MULTICYCLE_INST_COUNT_EN to implement the retired-instruction counter.
module multicycle_control (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  opcode,
    input  logic [5:0]  func,
    input  logic [15:0] nextPC,
    output logic [15:0] PC,
    output logic [14:0] signal,
    output logic [2:0]  state,
    output logic        is_halted,
    output logic [15:0] num_inst
);

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd5
    } state_t;

    state_t cur_state;
    state_t next_state;

    logic is_branch, is_adi, is_ori, is_lhi, is_lwd, is_swd, is_jmp;
    logic is_rtype, is_wwd, is_hlt, is_legal, is_counted;

    assign is_branch  = (opcode <= 4'd3);
    assign is_adi     = (opcode == 4'd4);
    assign is_ori     = (opcode == 4'd5);
    assign is_lhi     = (opcode == 4'd6);
    assign is_lwd     = (opcode == 4'd7);
    assign is_swd     = (opcode == 4'd8);
    assign is_jmp     = (opcode == 4'd9);
    assign is_rtype   = (opcode == 4'd15) && (func <= 6'd7);
    assign is_wwd     = (opcode == 4'd15) && (func == 6'd28);
    assign is_hlt     = (opcode == 4'd15) && (func == 6'd29);
    assign is_legal   = is_branch | is_adi | is_ori | is_lhi | is_lwd | is_swd
                      | is_jmp | is_rtype | is_wwd | is_hlt;
    assign is_counted = is_legal & ~is_hlt;

    always_ff @(posedge clk) begin
        if (!reset_n) cur_state <= S_IF;
        else          cur_state <= next_state;
    end

    always_comb begin
        next_state = S_IF;
        signal     = 15'h0000;
        case (cur_state)
            S_IF: begin
                signal     = 15'h0429;
                next_state = S_ID;
            end
            S_ID: begin
                signal = 15'h0800;
                if (is_hlt)        next_state = S_HALT;
                else if (!is_legal) next_state = S_IF;
                else               next_state = S_EX;
            end
            S_EX: begin
                if (is_rtype | is_wwd)                      signal = 15'h1200;
                else if (is_adi | is_lhi | is_lwd | is_swd) signal = 15'h1A00;
                else if (is_ori)                            signal = 15'h1E00;
                else if (is_branch)                         signal = 15'h2240;
                else if (is_jmp)                            signal = 15'h4020;
                if (is_branch | is_jmp)    next_state = S_IF;
                else if (is_lwd | is_swd)  next_state = S_MEM;
                else                       next_state = S_WB;
            end
            S_MEM: begin
                if (is_lwd) begin
                    signal     = 15'h0018;
                    next_state = S_WB;
                end else if (is_swd) begin
                    signal     = 15'h0014;
                end
            end
            S_WB: begin
                if (is_rtype | is_wwd)               signal = 15'h0180;
                else if (is_adi | is_ori | is_lhi)   signal = 15'h0100;
                else if (is_lwd)                     signal = 15'h0102;
            end
            S_HALT: next_state = S_HALT;
            default: next_state = S_IF;
        endcase
    end

    // PC follows the datapath in every working state and freezes once halted.
    always_ff @(posedge clk) begin
        if (!reset_n)                PC <= 16'h0000;
        else if (cur_state <= S_WB)  PC <= nextPC;
    end

    assign state     = cur_state;
    assign is_halted = (cur_state == S_HALT);

`ifdef MULTICYCLE_INST_COUNT_EN
    logic [15:0] inst_count;

    // An instruction retires from the count's point of view once it leaves ID legally.
    always_ff @(posedge clk) begin
        if (!reset_n)
            inst_count <= 16'h0000;
        else if (cur_state == S_ID && is_counted)
            inst_count <= inst_count + 16'd1;
    end

    assign num_inst = inst_count;
`else
    assign num_inst = 16'h0000;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: per-class control profiles drive a PC/count model.
// Honours MULTICYCLE_INST_COUNT_EN the same way as the design.
module tb_multicycle_control;

    logic        clk;
    logic        reset_n;
    logic [3:0]  opcode;
    logic [5:0]  func;
    logic [15:0] nextPC;
    logic [15:0] PC;
    logic [14:0] signal;
    logic [2:0]  state;
    logic        is_halted;
    logic [15:0] num_inst;

    multicycle_control dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .opcode    (opcode),
        .func      (func),
        .nextPC    (nextPC),
        .PC        (PC),
        .signal    (signal),
        .state     (state),
        .is_halted (is_halted),
        .num_inst  (num_inst)
    );

`ifdef MULTICYCLE_INST_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    logic [15:0] model_pc;
    logic [15:0] model_cnt;

    logic [14:0] prof_sig [0:4];
    logic [2:0]  prof_st  [0:4];
    int          prof_len;
    bit          prof_cnt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Expected per-cycle control words and states for one instruction, by class.
    task automatic buildProfile(input logic [3:0] op, input logic [5:0] fn);
        prof_sig[0] = 15'h0429; prof_st[0] = 3'd0;
        prof_sig[1] = 15'h0800; prof_st[1] = 3'd1;
        prof_len = 2;
        prof_cnt = 1'b1;
        prof_st[2] = 3'd2;
        if (op <= 4'd3) begin
            prof_sig[2] = 15'h2240; prof_len = 3;
        end else if (op == 4'd9) begin
            prof_sig[2] = 15'h4020; prof_len = 3;
        end else if (op == 4'd4 || op == 4'd6) begin
            prof_sig[2] = 15'h1A00; prof_sig[3] = 15'h0100; prof_st[3] = 3'd4; prof_len = 4;
        end else if (op == 4'd5) begin
            prof_sig[2] = 15'h1E00; prof_sig[3] = 15'h0100; prof_st[3] = 3'd4; prof_len = 4;
        end else if (op == 4'd7) begin
            prof_sig[2] = 15'h1A00; prof_sig[3] = 15'h0018; prof_st[3] = 3'd3;
            prof_sig[4] = 15'h0102; prof_st[4] = 3'd4; prof_len = 5;
        end else if (op == 4'd8) begin
            prof_sig[2] = 15'h1A00; prof_sig[3] = 15'h0014; prof_st[3] = 3'd3; prof_len = 4;
        end else if (op == 4'd15 && (fn <= 6'd7 || fn == 6'd28)) begin
            prof_sig[2] = 15'h1200; prof_sig[3] = 15'h0180; prof_st[3] = 3'd4; prof_len = 4;
        end else begin
            prof_cnt = 1'b0;
        end
    endtask

    task automatic checkAll(input string tag, input logic [14:0] exp_sig,
                            input logic [2:0] exp_st, input logic exp_halt);
        checkOutput({tag, "_sig"}, {1'b0, signal}, {1'b0, exp_sig});
        checkOutput({tag, "_state"}, {13'd0, state}, {13'd0, exp_st});
        checkOutput({tag, "_pc"}, PC, model_pc);
        checkOutput({tag, "_halt"}, {15'd0, is_halted}, {15'd0, exp_halt});
        checkOutput({tag, "_cnt"}, num_inst, model_cnt);
    endtask

    task automatic applyReset();
        reset_n = 1'b0;
        nextPC  = 16'($urandom);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n   = 1'b1;
        model_pc  = 16'h0000;
        model_cnt = 16'h0000;
        checkAll("reset", 15'h0429, 3'd0, 1'b0);
    endtask

    // mode 0: random nextPC; 1: PC+1 in IF, PC elsewhere; 2: like 1 but 16'h0ABC in EX.
    task automatic applyStimulus(input logic [3:0] op, input logic [5:0] fn,
                                 input int mode, input int stop_at);
        int n;
        opcode = op;
        func   = fn;
        buildProfile(op, fn);
        n = (stop_at > 0 && stop_at < prof_len) ? stop_at : prof_len;
        for (int i = 0; i < n; i++) begin
            checkAll($sformatf("op%0d_f%0d_c%0d", op, fn, i), prof_sig[i], prof_st[i], 1'b0);
            case (mode)
                1:       nextPC = (i == 0) ? model_pc + 16'd1 : model_pc;
                2:       nextPC = (i == 2) ? 16'h0ABC : ((i == 0) ? model_pc + 16'd1 : model_pc);
                default: nextPC = 16'($urandom);
            endcase
            @(posedge clk);
            model_pc = nextPC;
            if (i == 1 && prof_cnt && CNT_EN) model_cnt = model_cnt + 16'd1;
            @(negedge clk);
        end
    endtask

    initial begin
        logic [3:0] rop;
        logic [5:0] rfn;
        reset_n = 1'b0;
        opcode  = 4'd0;
        func    = 6'd0;
        nextPC  = 16'h0000;
        model_pc  = 16'h0000;
        model_cnt = 16'h0000;

        applyReset();

        applyStimulus(4'd15, 6'd0, 1, 0);
        checkAll("add_done", 15'h0429, 3'd0, 1'b0);
        checkOutput("add_pc1", PC, 16'h0001);

        applyStimulus(4'd7, 6'd0, 0, 0);
        applyStimulus(4'd9, 6'd0, 2, 0);
        checkOutput("jmp_target", PC, 16'h0ABC);

        applyStimulus(4'd11, 6'd0, 0, 0);
        checkAll("illegal_back", 15'h0429, 3'd0, 1'b0);

        for (int k = 0; k < 40; k++) begin
            rop = 4'($urandom_range(0, 15));
            rfn = 6'($urandom);
            if (rop == 4'd15) begin
                case ($urandom_range(0, 3))
                    0:       rfn = 6'($urandom_range(0, 7));
                    1:       rfn = 6'd28;
                    default: rfn = 6'($urandom_range(8, 27));
                endcase
            end
            applyStimulus(rop, rfn, 0, 0);
        end
        checkAll("rand_done", 15'h0429, 3'd0, 1'b0);

        applyStimulus(4'd7, 6'd0, 0, 3);
        applyReset();

`ifdef MULTICYCLE_INST_COUNT_EN
        force dut.inst_count = 16'hFFFF;
        #1;
        release dut.inst_count;
        model_cnt = 16'hFFFF;
        applyStimulus(4'd4, 6'd0, 0, 0);
        checkOutput("cnt_wrap", num_inst, 16'h0000);
        applyStimulus(4'd11, 6'd0, 0, 0);
        checkOutput("cnt_illegal", num_inst, 16'h0000);
`else
        applyStimulus(4'd4, 6'd0, 0, 0);
        applyStimulus(4'd11, 6'd0, 0, 0);
        checkOutput("cnt_disabled", num_inst, 16'h0000);
`endif

        applyStimulus(4'd15, 6'd29, 0, 0);
        for (int c = 0; c < 10; c++) begin
            checkAll($sformatf("halt_c%0d", c), 15'h0000, 3'd5, 1'b1);
            nextPC = ~nextPC;
            @(posedge clk);
            @(negedge clk);
        end
        applyReset();
        checkOutput("post_halt_pc", PC, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
